// File: rtl/uart_tx_store_fifo.sv
// Store-address decoded byte FIFO feeding a uart_tx instance one byte at a time.
// Optional drop counter port enabled by `UART_TX_FIFO_DROP_COUNT_EN.
module uart_tx_store_fifo #(
    parameter logic [31:0] ADDR  = 32'h10000100,
    parameter int          DEPTH = 8,
    parameter int          LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   data_out,
    input  logic          store_addr_out,
    input  logic          store_data_out,
    output logic          uart_tx_en,
    output logic [7:0]    uart_tx_data,
    input  logic          uart_tx_busy,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [LW-1:0] level,
`ifdef UART_TX_FIFO_DROP_COUNT_EN
    output logic [7:0]    drop_count,
`endif
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GUARD = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [1:0]    state;
    logic          sel;
    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign fifo_full  = (level == LW'(DEPTH));
    assign fifo_empty = (level == '0);
    assign push_req   = store_data_out && sel;
    assign pop        = (state == IDLE) && !fifo_empty && !uart_tx_busy;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= 1'b0;
        end else if (store_addr_out) begin
            sel <= (data_out == ADDR);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_out[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UART_TX_FIFO_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 8'h00;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

    // GUARD spans the cycle before uart_tx can report busy for the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            uart_tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        uart_tx_data <= mem[rd_ptr];
                        uart_tx_en   <= 1'b1;
                        state        <= GUARD;
                    end
                end
                GUARD: state <= WAIT;
                WAIT: begin
                    if (!uart_tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
